// File: rtl/rv32_m_arbiter.sv
// rtl/rv32_m_arbiter.sv - round-robin arbiter sharing one RV32M unit among NUM_REQ requesters
// Optional one-entry result cache: define RV32_M_ARB_RESULT_CACHE_EN.
`ifndef XLEN
`define XLEN 32
`endif

module rv32_m_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*`XLEN-1:0] i_rs1,
    input  logic [NUM_REQ*`XLEN-1:0] i_rs2,
    input  logic [NUM_REQ*3-1:0]     i_f3,
    output logic [`XLEN-1:0]         o_res,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic                     o_busy,
    output logic                     o_m_en,
    output logic [`XLEN-1:0]         o_m_rs1,
    output logic [`XLEN-1:0]         o_m_rs2,
    output logic [2:0]               o_m_f3,
    input  logic [`XLEN-1:0]         i_m_res,
    input  logic                     i_m_ack
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, grant, pick, rr_nxt;
    logic              pick_vld;
    logic [`XLEN-1:0]  sel_rs1, sel_rs2;
    logic [2:0]        sel_f3;
    logic [IDX_W:0]    sum;
    logic [2*NUM_REQ-1:0] req_rot;
    logic              hit, hit_q;

    // Rotate the request vector so bit 0 is the requester at rr_ptr.
    always_comb begin
        req_rot  = {i_req, i_req} >> rr_ptr;
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && req_rot[i]) begin
                pick_vld = 1'b1;
                sum      = {1'b0, rr_ptr} + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(NUM_REQ))
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                pick     = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        sel_f3  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                sel_rs1 = i_rs1[k*`XLEN +: `XLEN];
                sel_rs2 = i_rs2[k*`XLEN +: `XLEN];
                sel_f3  = i_f3[k*3 +: 3];
            end
        end
    end

    always_comb begin
        rr_nxt = grant + 1'b1;
        if ({1'b0, grant} == (IDX_W+1)'(NUM_REQ - 1))
            rr_nxt = '0;
    end

`ifdef RV32_M_ARB_RESULT_CACHE_EN
    logic             c_valid;
    logic [`XLEN-1:0] c_rs1, c_rs2, c_res;
    logic [2:0]       c_f3;

    assign hit = c_valid && (c_rs1 == sel_rs1) && (c_rs2 == sel_rs2) && (c_f3 == sel_f3);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            c_valid <= 1'b0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_f3    <= '0;
            c_res   <= '0;
        end else if (state == S_WAIT && i_m_ack) begin
            c_valid <= 1'b1;
            c_rs1   <= o_m_rs1;
            c_rs2   <= o_m_rs2;
            c_f3    <= o_m_f3;
            c_res   <= i_m_res;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            hit_q   <= 1'b0;
            o_res   <= '0;
            o_m_rs1 <= '0;
            o_m_rs2 <= '0;
            o_m_f3  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (pick_vld) begin
                    grant   <= pick;
                    o_m_rs1 <= sel_rs1;
                    o_m_rs2 <= sel_rs2;
                    o_m_f3  <= sel_f3;
                    hit_q   <= hit;
`ifdef RV32_M_ARB_RESULT_CACHE_EN
                    if (hit)
                        o_res <= c_res;
`endif
                end
                S_WAIT: if (i_m_ack) o_res <= i_m_res;
                S_RESP: rr_ptr <= rr_nxt;
                default: ;
            endcase
        end
    end

    // A cache hit spends its ISSUE cycle silently and goes straight to RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = hit_q ? S_RESP : S_WAIT;
            S_WAIT:  if (i_m_ack) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_ack = '0;
        if (state == S_RESP)
            o_ack[grant] = 1'b1;
    end

    assign o_m_en = (state == S_ISSUE) && !hit_q;
    assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_rv32_m_arbiter.sv
// tb/tb_rv32_m_arbiter.sv - scoreboard bench for rv32_m_arbiter with a behavioural M unit
module tb_rv32_m_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [1:0]  i_req;
    logic [63:0] i_rs1, i_rs2;
    logic [5:0]  i_f3;
    logic [31:0] o_res;
    logic [1:0]  o_ack;
    logic        o_busy, o_m_en;
    logic [31:0] o_m_rs1, o_m_rs2;
    logic [2:0]  o_m_f3;
    logic [31:0] i_m_res;
    logic        i_m_ack;

    logic [31:0] rs1_a [2];
    logic [31:0] rs2_a [2];
    logic [2:0]  f3_a  [2];

    assign i_rs1 = {rs1_a[1], rs1_a[0]};
    assign i_rs2 = {rs2_a[1], rs2_a[0]};
    assign i_f3  = {f3_a[1], f3_a[0]};

    rv32_m_arbiter #(.NUM_REQ(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_f3(i_f3),
        .o_res(o_res), .o_ack(o_ack), .o_busy(o_busy),
        .o_m_en(o_m_en), .o_m_rs1(o_m_rs1), .o_m_rs2(o_m_rs2), .o_m_f3(o_m_f3),
        .i_m_res(i_m_res), .i_m_ack(i_m_ack)
    );

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int mack_cyc = 0;
    int gen = 0;
    int stray_cnt = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial forever begin
        @(posedge i_clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an ack.
    initial forever begin
        exp_t e;
        @(negedge i_clk);
        if (o_m_en) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (i_m_ack) mack_cyc = cyc;
        if (o_ack != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, o_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", {30'd0, o_ack}, {30'd0, e.ack});
                check("ack_result", o_res, e.res);
            end
        end
    end

    // Behavioural M unit: acks 3 cycles after the start pulse; reset aborts it.
    initial begin
        int g;
        int stray_done;
        logic [31:0] a, b;
        logic [2:0]  f;
        stray_done = 0;
        i_m_ack = 1'b0;
        i_m_res = '0;
        forever begin
            @(negedge i_clk);
            if (stray_cnt != stray_done) begin
                stray_done++;
                @(posedge i_clk); #1;
                i_m_ack = 1'b1;
                i_m_res = 32'hDEAD;
                @(posedge i_clk); #1;
                i_m_ack = 1'b0;
            end else if (o_m_en) begin
                g = gen;
                a = o_m_rs1;
                b = o_m_rs2;
                f = o_m_f3;
                repeat (3) @(posedge i_clk);
                #1;
                if (g == gen) begin
                    i_m_ack = 1'b1;
                    if (f == 3'b100)
                        i_m_res = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
                    else
                        i_m_res = a * b;
                    @(posedge i_clk); #1;
                    i_m_ack = 1'b0;
                end
            end
        end
    end

    task automatic wait_ack(input string name, output logic [1:0] a);
        a = 2'b00;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (o_ack != 2'b00) begin
                a = o_ack;
                return;
            end
        end
        check({name, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_en(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_m_en) return;
        end
        check({name, "_en_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        gen++;
        i_req = 2'b00;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
    endtask

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        rs1_a[k] = a;
        rs2_a[k] = b;
        f3_a[k]  = f;
    endtask

    initial begin
        logic [1:0] a;
        int t_req, t_ack, en0;
        i_rst = 1'b0;
        i_req = 2'b00;
        set_ops(0, 0, 0, 0);
        set_ops(1, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_ack",  {30'd0, o_ack}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_en",   {31'd0, o_m_en}, 32'd0);
        check("rst_res",  o_res, 32'd0);
        check("rst_rs1",  o_m_rs1, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;

        // 1: single request, 7*6
        @(posedge i_clk); #1;
        set_ops(0, 32'd7, 32'd6, 3'b000);
        i_req = 2'b01;
        t_req = cyc;
        en0 = en_cnt;
        sb.push_back('{2'b01, 32'd42});
        wait_en("t1");
        check("t1_en_latency", 32'(en_cyc), 32'(t_req + 1));
        wait_ack("t1", a);
        t_ack = cyc;
        check("t1_mack_latency", 32'(mack_cyc), 32'(en_cyc + 3));
        check("t1_ack_latency", 32'(t_ack), 32'(mack_cyc + 1));
        @(posedge i_clk); #1;
        i_req = 2'b00;
        check("t1_en_count", 32'(en_cnt), 32'(en0 + 1));

        // 2: contention from rr_ptr=0, requester 0 re-requests behind requester 1
        do_reset();
        @(posedge i_clk); #1;
        set_ops(0, 32'd3, 32'd5, 3'b000);
        set_ops(1, 32'd4, 32'd9, 3'b000);
        i_req = 2'b11;
        sb.push_back('{2'b01, 32'd15});
        sb.push_back('{2'b10, 32'd36});
        sb.push_back('{2'b01, 32'd4});
        wait_ack("t2a", a);
        check("t2_first", {30'd0, a}, 32'd1);
        @(posedge i_clk); #1;
        set_ops(0, 32'd2, 32'd2, 3'b000);
        wait_ack("t2b", a);
        check("t2_second", {30'd0, a}, 32'd2);
        @(posedge i_clk); #1;
        i_req[1] = 1'b0;
        wait_ack("t2c", a);
        check("t2_third", {30'd0, a}, 32'd1);
        @(posedge i_clk); #1;
        i_req = 2'b00;

        // 3: operand change after grant has no effect
        @(posedge i_clk); #1;
        set_ops(1, 32'h10, 32'd1, 3'b000);
        i_req = 2'b10;
        sb.push_back('{2'b10, 32'h10});
        wait_en("t3");
        @(posedge i_clk); #1;
        rs1_a[1] = 32'h20;
        @(negedge i_clk);
        check("t3_rs1_latched", o_m_rs1, 32'h10);
        wait_ack("t3", a);
        @(posedge i_clk); #1;
        i_req = 2'b00;

        // 4: async reset while waiting on the M unit
        @(posedge i_clk); #1;
        set_ops(0, 32'd5, 32'd5, 3'b000);
        i_req = 2'b01;
        wait_en("t4");
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        gen++;
        i_req = 2'b00;
        #1;
        check("t4_rst_busy", {31'd0, o_busy}, 32'd0);
        check("t4_rst_ack",  {30'd0, o_ack}, 32'd0);
        check("t4_rst_rs1",  o_m_rs1, 32'd0);
        check("t4_rst_res",  o_res, 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        repeat (8) @(posedge i_clk);
        #1;
        set_ops(0, 32'd9, 32'd3, 3'b000);
        i_req = 2'b01;
        sb.push_back('{2'b01, 32'd27});
        wait_ack("t4", a);
        @(posedge i_clk); #1;
        i_req = 2'b00;

        // 5: DIV -8/2 twice from different requesters
        @(posedge i_clk); #1;
        set_ops(0, 32'hFFFF_FFF8, 32'd2, 3'b100);
        i_req = 2'b01;
        sb.push_back('{2'b01, 32'hFFFF_FFFC});
        wait_ack("t5a", a);
        @(posedge i_clk); #1;
        i_req = 2'b00;
        @(posedge i_clk); #1;
        set_ops(1, 32'hFFFF_FFF8, 32'd2, 3'b100);
        i_req = 2'b10;
        t_req = cyc;
        en0 = en_cnt;
        sb.push_back('{2'b10, 32'hFFFF_FFFC});
        wait_ack("t5b", a);
        t_ack = cyc;
        @(posedge i_clk); #1;
        i_req = 2'b00;
`ifdef RV32_M_ARB_RESULT_CACHE_EN
        check("t5_hit_latency", 32'(t_ack), 32'(t_req + 2));
        check("t5_hit_no_en", 32'(en_cnt), 32'(en0));
`else
        check("t5_miss_latency", 32'(t_ack), 32'(t_req + 5));
        check("t5_miss_en", 32'(en_cnt), 32'(en0 + 1));
`endif

        // 6: stray M ack in IDLE, then a request held across its ack
        @(posedge i_clk); #1;
        stray_cnt++;
        repeat (4) @(posedge i_clk);
        #1;
        check("t6_stray_busy", {31'd0, o_busy}, 32'd0);
        set_ops(0, 32'd3, 32'd3, 3'b000);
        i_req = 2'b01;
        en0 = en_cnt;
        sb.push_back('{2'b01, 32'd9});
        sb.push_back('{2'b01, 32'd9});
        wait_ack("t6a", a);
        wait_ack("t6b", a);
        @(posedge i_clk); #1;
        i_req = 2'b00;
`ifdef RV32_M_ARB_RESULT_CACHE_EN
        check("t6_en_count", 32'(en_cnt), 32'(en0 + 1));
`else
        check("t6_en_count", 32'(en_cnt), 32'(en0 + 2));
`endif
        repeat (10) @(posedge i_clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
